// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC and reads the asynchronous ROM.
// Fetched {pc, instr} pairs go into a 2-entry buffer that decode drains over valid/ready.

`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module rom_fetch_ctrl #(
    parameter int                   ADDR_BITS = `ADDR_BITS,
    parameter int                   DATA_BITS = `DATA_BITS,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   halt,
    input  logic                   redir_valid,
    input  logic [ADDR_BITS-1:0]   redir_addr,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic [2*DATA_BITS-1:0] rom_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*DATA_BITS-1:0] out_instr,
    output logic [ADDR_BITS-1:0]   out_pc,
    output logic [ADDR_BITS-1:0]   pc,
    output logic [1:0]             fifo_count
);

    localparam int IW = 2 * DATA_BITS;

    typedef struct packed {
        logic [ADDR_BITS-1:0] pc;
        logic [IW-1:0]        instr;
    } entry_t;

    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [1:0]           count_q, count_d;
    entry_t               entry_q [2];
    entry_t               entry_d [2];
    entry_t               new_entry;
    logic                 pop;
    logic                 push;
    logic                 wr_sel;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        pop       = (count_q != 2'd0) & out_ready & ~redir_valid;
        push      = ~redir_valid & ~halt & ((count_q < 2'd2) | pop);
        wr_sel    = (count_q == 2'd2) | ((count_q == 2'd1) & ~pop);
        new_entry = '{pc: pc_q, instr: rom_data};
        pc_d       = pc_q;
        count_d    = count_q;
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];

        if (redir_valid) begin
            // Flush; the stale head stays visible but is no longer counted.
            pc_d    = redir_addr;
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                entry_d[0] = entry_q[1];
            end
            if (push) begin
                pc_d            = pc_q + 1'b1;
                entry_d[wr_sel] = new_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                entry_q[gi] <= '0;
            end else begin
                entry_q[gi] <= entry_d[gi];
            end
        end
    end

    assign rom_addr   = pc_q;
    assign pc         = pc_q;
    assign fifo_count = count_q;
    assign out_valid  = (count_q != 2'd0);
    assign out_instr  = entry_q[0].instr;
    assign out_pc     = entry_q[0].pc;

endmodule
